// File: rtl/seg_scan_capture.sv
// Receive-side monitor for a multiplexed four-digit seven-segment bus. It debounces each
// strobe/segment pattern, decodes settled digits back to hex, and flags frames and bad codes.
module seg_scan_capture #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter bit          SEL_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  sel,
  input  logic [6:0]  digits,
  output logic [15:0] value,
  output logic [3:0]  digit_valid,
  output logic        frame_done,
  output logic        bad_pattern,
  output logic [1:0]  bad_index
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_PRE = 8'(STABLE_CYCLES - 1);

  logic [3:0] sel_n;
  logic [6:0] seg_n;
  logic [3:0] samp_sel;
  logic [6:0] samp_seg;
  logic [7:0] cnt;
  logic [3:0] seen;

  logic       same;
  logic       one_hot;
  logic       commit;
  logic [1:0] idx;
  logic [4:0] dec;
  logic [3:0] seen_next;

  function automatic logic [4:0] decode(input logic [6:0] code);
    logic [4:0] r;
    r = '0;
    case (code)
      7'h3F: r = {1'b1, 4'h0};
      7'h06: r = {1'b1, 4'h1};
      7'h5B: r = {1'b1, 4'h2};
      7'h4F: r = {1'b1, 4'h3};
      7'h66: r = {1'b1, 4'h4};
      7'h6D: r = {1'b1, 4'h5};
      7'h7D: r = {1'b1, 4'h6};
      7'h07: r = {1'b1, 4'h7};
      7'h7F: r = {1'b1, 4'h8};
      7'h6F: r = {1'b1, 4'h9};
      7'h77: r = {1'b1, 4'hA};
      7'h7C: r = {1'b1, 4'hB};
      7'h39: r = {1'b1, 4'hC};
      7'h5E: r = {1'b1, 4'hD};
      7'h79: r = {1'b1, 4'hE};
      7'h71: r = {1'b1, 4'hF};
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    sel_n = SEL_ACTIVE_LOW ? ~sel : sel;
    seg_n = SEG_ACTIVE_LOW ? ~digits : digits;
  end

  // Commit is taken on the edge where the dwell counter steps from STABLE-1 to STABLE,
  // so it fires once per dwell and the result lands STABLE-1 edges after the first sample.
  always_comb begin
    same    = (sel_n == samp_sel) && (seg_n == samp_seg);
    one_hot = (samp_sel != '0) && ((samp_sel & (samp_sel - 4'd1)) == '0);
    commit  = same && one_hot && (cnt == CNT_PRE);
    idx     = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (samp_sel[i]) idx = 2'(i);
    end
    dec       = decode(samp_seg);
    seen_next = seen | samp_sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_sel    <= '0;
      samp_seg    <= '0;
      cnt         <= '0;
      seen        <= '0;
      value       <= '0;
      digit_valid <= '0;
      frame_done  <= 1'b0;
      bad_pattern <= 1'b0;
      bad_index   <= '0;
    end else begin
      frame_done  <= 1'b0;
      bad_pattern <= 1'b0;
      if (!same) begin
        samp_sel <= sel_n;
        samp_seg <= seg_n;
        cnt      <= 8'd1;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 8'd1;
      end
      if (commit) begin
        if (dec[4]) begin
          value[{idx, 2'b00} +: 4] <= dec[3:0];
          digit_valid[idx]         <= 1'b1;
        end else begin
          digit_valid[idx] <= 1'b0;
          bad_pattern      <= 1'b1;
          bad_index        <= idx;
        end
        if (seen_next == 4'hF) begin
          frame_done <= 1'b1;
          seen       <= '0;
        end else begin
          seen <= seen_next;
        end
      end
    end
  end

endmodule

// File: doc/seg_scan_capture.md
# seg_scan_capture

Loop-back monitor for the four-digit multiplexed seven-segment display bus (`sel`/`digits`) driven by `top`. It works at the receiving end of that bus. It watches the scan strobes and segment lines, waits for each pattern to settle, and decodes each settled digit back to a 4-bit hex value. It also reports complete display frames and illegal segment patterns. It is used in the board bench and can be kept on-chip as a self-check feeding the `led` bank.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: number of consecutive identical samples required before a digit is committed. Legal range 2..255.
- `SEL_ACTIVE_LOW`, default 1: 1 means `sel` is active-low one-hot. The block inverts `sel` internally before use.
- `SEG_ACTIVE_LOW`, default 0: 1 means `digits` is active-low. The block inverts `digits` internally before use.

Ports:
- `clk` in 1: system clock, same domain as the display driver.
- `rst` in 1: asynchronous, active-high reset.
- `sel` in 4: digit strobe. Bit i selects digit i.
- `digits` in 7: segments `{g,f,e,d,c,b,a}`.
- `value` out 16: decoded digits. Digit i occupies bits `[4i+3:4i]`.
- `digit_valid` out 4: bit i is set when digit i currently holds a good decode.
- `frame_done` out 1: one-cycle pulse when all four digits have been committed since the last pulse.
- `bad_pattern` out 1: one-cycle pulse when a committed pattern fails to decode.
- `bad_index` out 2: index of the last bad digit. It is held until the next bad pattern.

## Operation
- **Normalisation:** apply the polarity parameters to `sel` and `digits`. All rules below refer to the normalised, active-high values.
- **Sample register:** holds `{sel,digits}` and a saturating dwell counter `cnt`, 0..STABLE_CYCLES.
  - If the input differs from the sample register, reload the sample and set `cnt` to 1.
  - Otherwise, increment `cnt`, saturating at STABLE_CYCLES.
- **Commit:** fires on the single cycle where `cnt` reaches STABLE_CYCLES and the sampled `sel` is exactly one-hot. It fires exactly once per dwell, however long the dwell lasts.
- **Non-one-hot `sel`** (0000, or two or more bits set): these are blanking or transition states and never commit.
- **Decode table** (hex value = segment code):
  - 0=3F, 1=06, 2=5B, 3=4F
  - 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C
  - C=39, d=5E, E=79, F=71
  - Any other code is bad, including 00 (blank).
- **Good commit on digit i:** write the nibble into `value`, set `digit_valid[i]`, and set seen-mask bit i.
- **Bad commit on digit i:** leave the `value` nibble unchanged, clear `digit_valid[i]`, pulse `bad_pattern`, set `bad_index`=i, and set seen-mask bit i.
- **Frame completion:** when a commit makes the seen mask 1111, pulse `frame_done` in the same cycle as the commit's register update, and clear the mask to 0000. A repeated commit on an already-seen digit only overwrites that digit and does not advance the frame.
- **Reset:** `value`=0, `digit_valid`=0, `frame_done`=0, `bad_pattern`=0, `bad_index`=0, seen mask=0, `cnt`=0, sample register=0. Reset asserted mid-dwell discards the partial dwell. After reset is released, a new full dwell is required.

## Timing
- A pattern first sampled at edge k, and held, updates `value`, `digit_valid` and `bad_index` at edge k+STABLE_CYCLES-1. It is visible to logic from that edge onward.
- `frame_done` and `bad_pattern` are registered pulses, high for exactly one cycle, aligned with the commit's register update.
- A glitch shorter than STABLE_CYCLES samples never commits. It restarts the dwell of the pattern that follows it.
- The same digit re-selected after a different strobe counts as a new dwell and commits again.
- Throughput: at most one commit every STABLE_CYCLES cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Clean frame:** reset, then with STABLE_CYCLES=4 drive `sel`=1110, 1101, 1011, 0111, each for 8 cycles, with codes 06, 5B, 4F, 66. Required: `value`=16'h4321, `digit_valid`=1111, exactly one `frame_done` pulse coinciding with the digit-3 commit, and each update arriving 3 edges after the first sample.
- **Glitch rejection:** hold digit 0 at code 3F for 8 cycles with a 2-cycle burst of code 7F in the middle. Required: nibble 0 equals 0, and exactly two commits occur (before and after the burst). Nibble 0 never equals 8.
- **Bad pattern:** drive digit 2 at code 00, then at 12, each dwelling 6 cycles. Required: two `bad_pattern` pulses, `bad_index`=2, `digit_valid[2]`=0, and nibble 2 unchanged.
- **Non-one-hot `sel`:** drive `sel`=1111 and then `sel`=1100 with code 3F for 20 cycles. Required: no commit, no pulse, and all outputs unchanged.
- **Reset mid-operation:** complete two digits, then assert `rst` for 1 cycle mid-dwell of the third. Required: all outputs are 0 immediately, the seen mask is clear, and the next `frame_done` requires all four digits again.
- **Long dwell:** hold digit 1 at code 79 for 300 cycles. Required: exactly one commit, nibble 1 equals E, and `cnt` saturates without wrapping or recommitting.
